// File: rtl/uart_pkg.sv
// Frame constants and serialiser state encoding shared by the UART transmit scheduler.
package uart_pkg;

  localparam int DATA_BITS   = 8;
  localparam int FRAME_TICKS = 10;
  localparam int TICK_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request searched circularly from ptr_i.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  grant_id_o,
  output logic             valid_o
);

  localparam int SW = ID_W + 1;

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    logic [SW-1:0]   sum;
    logic [ID_W-1:0] idx;
    grant_id_o = '0;
    valid_o    = 1'b0;
    sum        = '0;
    idx        = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + SW'(k);
      if (sum >= SW'(N_REQ)) begin
        sum = sum - SW'(N_REQ);
      end
      idx = sum[ID_W-1:0];
      if (req_i[idx]) begin
        grant_id_o = idx;
        valid_o    = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign grant_o[gi] = valid_o && (grant_id_o == ID_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 UART transmit line between N_REQ byte producers,
// paced by the baud generator's one-cycle bit strobe.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 txclk_en,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_mask,
  output logic [N_REQ-1:0]     req_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 tx
);

  localparam logic [TICK_W-1:0] TICK_LAST_DATA = TICK_W'(DATA_BITS);
  localparam logic [TICK_W-1:0] TICK_STOP      = TICK_W'(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] TICK_END       = TICK_W'(FRAME_TICKS);

  state_e                 state_q, state_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic [ID_W-1:0]        gid_q, gid_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;

  logic [N_REQ-1:0]       arb_grant;
  logic [ID_W-1:0]        arb_id;
  logic                   arb_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i      (req_valid & req_mask),
    .ptr_i      (ptr_q),
    .grant_o    (arb_grant),
    .grant_id_o (arb_id),
    .valid_o    (arb_valid)
  );

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    gid_d     = gid_q;
    ptr_d     = ptr_q;
    req_ready = '0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // Accept is independent of txclk_en; a strobe this cycle is not used for the start bit.
        if (arb_valid) begin
          req_ready = arb_grant;
          shift_d   = req_data[{arb_id, 3'b000} +: DATA_BITS];
          gid_d     = arb_id;
          busy_d    = 1'b1;
          ptr_d     = (arb_id == ID_W'(N_REQ - 1)) ? '0 : arb_id + ID_W'(1);
          state_d   = ARMED;
        end
      end

      ARMED: begin
        if (txclk_en) begin
          tx_d    = 1'b0;
          tick_d  = TICK_W'(1);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (tick_q == '0 || tick_q > TICK_END) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          tick_d  = '0;
          state_d = IDLE;
        end else if (txclk_en) begin
          if (tick_q <= TICK_LAST_DATA) begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            tick_d  = tick_q + TICK_W'(1);
          end else if (tick_q == TICK_STOP) begin
            tx_d   = 1'b1;
            tick_d = tick_q + TICK_W'(1);
          end else begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            tick_d  = '0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        tick_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      gid_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: accepts push expected bytes, a strobe-synchronous
// receiver pops and compares them.
module tb_uart_tx_sched;

  localparam int N = 4;

  logic           clk_50m;
  logic           rst_n;
  logic           txclk_en;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_mask;
  logic [N-1:0]   req_ready;
  logic [1:0]     grant_id;
  logic           busy;
  logic           tx;

  int checks = 0;
  int errors = 0;
  int period = 4;
  bit force_en = 1'b0;
  int scnt = 0;

  logic [7:0] exp_q[$];
  int         glog[$];
  int         mptr = 0;
  int         rx_cnt = -1;
  logic [7:0] rx_byte = '0;
  bit         await_end = 1'b0;
  bit         prev_en = 1'b0;
  bit         pend_gid = 1'b0;
  int         exp_gid = 0;

  uart_tx_sched #(.N_REQ(N)) dut (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .txclk_en  (txclk_en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_mask  (req_mask),
    .req_ready (req_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .tx        (tx)
  );

  initial clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] elig, input int p);
    for (int k = 0; k < N; k++) begin
      if (elig[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Bit strobe generator: period 0 = off, 1 = tied high, else every period cycles.
  initial begin
    txclk_en = 1'b0;
    forever begin
      @(posedge clk_50m);
      #2;
      scnt++;
      if (force_en || period == 1) txclk_en = 1'b1;
      else if (period > 1 && (scnt % period) == 0) txclk_en = 1'b1;
      else txclk_en = 1'b0;
    end
  end

  // Scoreboard: model arbiter on accept, serial receiver on each strobe edge.
  initial begin
    forever begin
      @(negedge clk_50m);
      if (!rst_n) begin
        mptr = 0;
        exp_q.delete();
        rx_cnt = -1;
        await_end = 1'b0;
        prev_en = 1'b0;
        pend_gid = 1'b0;
      end else begin
        bit strobe_edge;
        strobe_edge = prev_en;
        prev_en = txclk_en;
        if (pend_gid) begin
          check_eq("grant_id", grant_id, exp_gid);
          pend_gid = 1'b0;
        end
        if (strobe_edge) begin
          if (await_end) begin
            check_eq("busy_end", busy, 0);
            await_end = 1'b0;
          end else if (rx_cnt < 0) begin
            if (tx == 1'b0) begin
              rx_cnt = 0;
              rx_byte = '0;
            end
          end else if (rx_cnt < 8) begin
            rx_byte[rx_cnt] = tx;
            rx_cnt++;
          end else begin
            check_eq("stop_bit", tx, 1);
            check_eq("busy_stop", busy, 1);
            if (exp_q.size() == 0) check_eq("rx_unexpected", 1, 0);
            else check_eq("rx_byte", rx_byte, exp_q.pop_front());
            $display("FRAME byte %02h at %0t", rx_byte, $time);
            rx_cnt = -1;
            await_end = 1'b1;
          end
        end
        if (req_ready != '0) begin
          int win;
          win = rr_pick(req_valid & req_mask, mptr);
          if (win < 0) begin
            check_eq("req_ready_spurious", req_ready, 0);
          end else begin
            check_eq("req_ready", req_ready, 32'(1) << win);
            exp_q.push_back(req_data[8*win +: 8]);
            glog.push_back(win);
            exp_gid = win;
            pend_gid = 1'b1;
            mptr = (win + 1) % N;
            $display("ACCEPT req %0d byte %02h at %0t", win, req_data[8*win +: 8], $time);
          end
        end
      end
    end
  end

  task automatic wait_accept(input bit drop);
    logic [N-1:0] r;
    bit seen;
    seen = 1'b0;
    r = '0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk_50m);
      if (req_ready != '0) begin
        seen = 1'b1;
        r = req_ready;
      end
    end
    if (!seen) begin
      check_eq("accept_timeout", 0, 1);
    end else begin
      @(posedge clk_50m);
      #1;
      if (drop) req_valid = req_valid & ~r;
      @(negedge clk_50m);
      check_eq("ready_pulse", req_ready, 0);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 800 && !done; c++) begin
      @(negedge clk_50m);
      if (!busy && exp_q.size() == 0 && rx_cnt < 0 && !await_end && req_ready == '0) done = 1'b1;
    end
    if (!done) check_eq("idle_timeout", 0, 1);
  endtask

  task automatic apply_reset();
    @(posedge clk_50m);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk_50m);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_order(input string tag, input int base, input int n, input int e0,
                             input int e1, input int e2, input int e3, input int e4);
    int exp_a[5];
    exp_a = '{e0, e1, e2, e3, e4};
    for (int i = 0; i < n; i++) begin
      if (glog.size() <= base + i) check_eq(tag, 32'hffff_ffff, exp_a[i]);
      else check_eq(tag, glog[base + i], exp_a[i]);
    end
  endtask

  initial begin
    int cnt;
    int bad;
    int base;
    int n;
    rst_n = 1'b0;
    req_valid = '0;
    req_mask = 4'hF;
    req_data = '0;

    repeat (3) @(negedge clk_50m);
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_gid", grant_id, 0);
    @(posedge clk_50m);
    #1 rst_n = 1'b1;

    // Single frame 0xA5 from requester 0.
    @(posedge clk_50m);
    #1 req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    wait_accept(1'b1);
    wait_idle();

    // Reset in the middle of a frame.
    @(posedge clk_50m);
    #1 req_data[15:8] = 8'h77;
    req_valid = 4'b0010;
    wait_accept(1'b1);
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 5; c++) begin
      @(posedge clk_50m);
      if (txclk_en) cnt++;
    end
    #5 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_tx", tx, 1);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_gid", grant_id, 0);
    repeat (3) @(posedge clk_50m);
    #1 rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk_50m);
      if (busy || req_ready != '0 || tx !== 1'b1) bad++;
    end
    check_eq("post_rst_quiet", bad, 0);

    // Round robin with all requesters continuously valid.
    base = glog.size();
    @(posedge clk_50m);
    #1 req_data = 32'h1312_1110;
    req_valid = 4'hF;
    repeat (5) wait_accept(1'b0);
    @(posedge clk_50m);
    #1 req_valid = '0;
    wait_idle();
    check_order("rr_order", base, 5, 0, 1, 2, 3, 0);

    // Masked requesters are skipped.
    apply_reset();
    base = glog.size();
    @(posedge clk_50m);
    #1 req_mask = 4'b1010;
    req_valid = 4'hF;
    repeat (4) wait_accept(1'b0);
    @(posedge clk_50m);
    #1 req_valid = '0;
    req_mask = 4'hF;
    wait_idle();
    check_order("mask_order", base, 4, 1, 3, 1, 3, 0);

    // Pointer wrap after a grant to 3.
    base = glog.size();
    @(posedge clk_50m);
    #1 req_valid = 4'b0101;
    wait_accept(1'b1);
    wait_accept(1'b1);
    wait_idle();
    check_order("wrap_order", base, 2, 0, 2, 0, 0, 0);

    // Accept coincident with a strobe: start bit must wait for a later strobe.
    period = 0;
    repeat (2) @(posedge clk_50m);
    #1 req_data[15:8] = 8'h96;
    req_valid = 4'b0010;
    force_en = 1'b1;
    @(negedge clk_50m);
    check_eq("simul_ready", req_ready, 4'b0010);
    @(posedge clk_50m);
    #1 force_en = 1'b0;
    req_valid = '0;
    @(negedge clk_50m);
    check_eq("simul_no_start", tx, 1);
    check_eq("simul_busy", busy, 1);
    repeat (3) @(negedge clk_50m);
    check_eq("armed_hold", tx, 1);
    period = 4;
    wait_idle();

    // Strobe tied high, back-to-back frames.
    period = 1;
    base = glog.size();
    @(posedge clk_50m);
    #1 req_data[23:16] = 8'h3C;
    req_data[31:24] = 8'hC3;
    req_valid = 4'b1100;
    wait_accept(1'b1);
    n = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_50m);
      if (!busy) break;
      n++;
    end
    check_eq("tied_len", n, 11);
    check_eq("b2b_ready", req_ready, 4'b1000);
    @(posedge clk_50m);
    #1 req_valid = '0;
    wait_idle();
    check_order("tied_order", base, 2, 2, 3, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
